// File: rtl/led_pkg.sv
// Shared types and 50 MHz default timing for the WS2812-style chain node.
package led_pkg;

    typedef enum logic [1:0] {
        SYNC,
        CAPTURE,
        PASSTHRU
    } node_state_e;

    localparam int T0H              = 20;
    localparam int T1H              = 40;
    localparam int DEF_BIT_THRESH   = 30;
    localparam int DEF_LATCH_CYCLES = 2500;

endpackage

// File: rtl/led_pulse_timer.sv
// Serial line synchroniser, edge detect, high/low run counters and latch strobe.
module led_pulse_timer
    import led_pkg::*;
#(
    parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
    parameter int CNT_W        = $clog2(LATCH_CYCLES + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_serial,
    output logic             sig_q,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] high_cnt,
    output logic             latch
);

    localparam logic [CNT_W-1:0] HIGH_MAX = '1;
    localparam logic [CNT_W-1:0] LOW_MAX  = CNT_W'(LATCH_CYCLES);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic             meta_q;
    logic             sig_qq;
    logic [CNT_W-1:0] high_q;
    logic [CNT_W-1:0] high_d;
    logic [CNT_W-1:0] low_q;
    logic [CNT_W-1:0] low_d;

    assign rise     = sig_q & ~sig_qq;
    assign fall     = ~sig_q & sig_qq;
    assign high_cnt = high_q;

    // The edge cycle itself counts, so a run of N cycles reads N at the opposite edge.
    always_comb begin
        high_d = high_q;
        low_d  = low_q;
        if (rise) begin
            high_d = ONE;
        end else if (sig_q && high_q != HIGH_MAX) begin
            high_d = high_q + ONE;
        end
        if (fall) begin
            low_d = ONE;
        end else if (!sig_q && low_q != LOW_MAX) begin
            low_d = low_q + ONE;
        end
    end

    assign latch = (low_d == LOW_MAX) && (low_q != LOW_MAX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= 1'b0;
            sig_q  <= 1'b0;
            sig_qq <= 1'b0;
            high_q <= '0;
            low_q  <= '0;
        end else begin
            meta_q <= i_serial;
            sig_q  <= meta_q;
            sig_qq <= sig_q;
            high_q <= high_d;
            low_q  <= low_d;
        end
    end

endmodule

// File: rtl/led_chain_node.sv
// One node of a WS2812-style chain: capture, forward, commit on latch gap.
// Define LED_PULSE_CHECK_EN to add the sticky pulse-width error output o_err.
module led_chain_node
    import led_pkg::*;
#(
    parameter int NUM_PIXELS     = 2,
    parameter int BITS_PER_PIXEL = 24,
    parameter int BIT_THRESH     = DEF_BIT_THRESH,
    parameter int LATCH_CYCLES   = DEF_LATCH_CYCLES
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_serial,
    output logic                                 o_serial,
    output logic [NUM_PIXELS*BITS_PER_PIXEL-1:0] o_led_data,
    output logic                                 o_frame_valid,
    output logic                                 o_busy
`ifdef LED_PULSE_CHECK_EN
    ,
    output logic                                 o_err
`endif
);

    localparam int CNT_W = $clog2(LATCH_CYCLES + 1);
    localparam int TOTAL = NUM_PIXELS * BITS_PER_PIXEL;
    localparam int BC_W  = $clog2(TOTAL + 1);

    localparam logic [BC_W-1:0] LAST = BC_W'(TOTAL - 1);
    localparam logic [BC_W-1:0] BONE = BC_W'(1);

    logic             sig_q;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] high_cnt;
    logic             latch;
    logic [31:0]      high_ext;
    logic             bit_val;
    logic             commit_ok;
    logic             unused_rise;

    node_state_e      state_q;
    node_state_e      state_d;
    logic [BC_W-1:0]  bit_cnt_q;
    logic [BC_W-1:0]  bit_cnt_d;
    logic [TOTAL-1:0] shadow_q;
    logic [TOTAL-1:0] shadow_d;
    logic [TOTAL-1:0] led_q;
    logic [TOTAL-1:0] led_d;
    logic             valid_q;
    logic             valid_d;
    logic             serial_q;
    logic             serial_d;
    logic             busy_q;
    logic             busy_d;

    led_pulse_timer #(
        .LATCH_CYCLES (LATCH_CYCLES),
        .CNT_W        (CNT_W)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_serial (i_serial),
        .sig_q    (sig_q),
        .rise     (rise),
        .fall     (fall),
        .high_cnt (high_cnt),
        .latch    (latch)
    );

    assign unused_rise = rise;
    assign high_ext    = 32'(high_cnt);
    assign bit_val     = high_ext >= 32'(BIT_THRESH);

`ifdef LED_PULSE_CHECK_EN
    logic err_q;
    logic err_d;
    logic ferr_q;
    logic ferr_d;
    logic bad_pulse;

    assign bad_pulse = (high_ext < 32'(BIT_THRESH / 2))
                     || (high_ext >= 32'(2 * BIT_THRESH));
    assign commit_ok = !ferr_q;
    assign o_err     = err_q;
`else
    assign commit_ok = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shadow_d  = shadow_q;
        led_d     = led_q;
        valid_d   = 1'b0;
        serial_d  = 1'b0;
`ifdef LED_PULSE_CHECK_EN
        err_d     = err_q;
        ferr_d    = ferr_q;
`endif
        unique case (state_q)
            SYNC: begin
                if (latch) begin
                    state_d   = CAPTURE;
                    bit_cnt_d = '0;
                end
            end
            CAPTURE: begin
                if (fall) begin
                    shadow_d  = {shadow_q[TOTAL-2:0], bit_val};
                    bit_cnt_d = bit_cnt_q + BONE;
                    if (bit_cnt_q == LAST) begin
                        state_d = PASSTHRU;
                    end
`ifdef LED_PULSE_CHECK_EN
                    if (bad_pulse) begin
                        err_d  = 1'b1;
                        ferr_d = 1'b1;
                    end
`endif
                end else if (latch) begin
                    // Short frame: drop it, keep the committed data.
                    bit_cnt_d = '0;
`ifdef LED_PULSE_CHECK_EN
                    ferr_d    = 1'b0;
`endif
                end
            end
            PASSTHRU: begin
                serial_d = sig_q;
                if (latch) begin
                    if (commit_ok) begin
                        led_d   = shadow_q;
                        valid_d = 1'b1;
                    end
                    state_d   = CAPTURE;
                    bit_cnt_d = '0;
`ifdef LED_PULSE_CHECK_EN
                    ferr_d    = 1'b0;
`endif
                end
            end
            default: begin
                state_d = SYNC;
            end
        endcase
        busy_d = (state_d == CAPTURE) && (bit_cnt_d != '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= SYNC;
            bit_cnt_q <= '0;
            shadow_q  <= '0;
            led_q     <= '0;
            valid_q   <= 1'b0;
            serial_q  <= 1'b0;
            busy_q    <= 1'b0;
`ifdef LED_PULSE_CHECK_EN
            err_q     <= 1'b0;
            ferr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shadow_q  <= shadow_d;
            led_q     <= led_d;
            valid_q   <= valid_d;
            serial_q  <= serial_d;
            busy_q    <= busy_d;
`ifdef LED_PULSE_CHECK_EN
            err_q     <= err_d;
            ferr_q    <= ferr_d;
`endif
        end
    end

    assign o_serial      = serial_q;
    assign o_led_data    = led_q;
    assign o_frame_valid = valid_q;
    assign o_busy        = busy_q;

endmodule
